// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the main-memory port between icache and dcache
// One memory transaction in flight; every output is a flop.
module mem_arbiter #(
   parameter int ADDR_W  = 20,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              ic_rqst_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic              dc_rqst_i,
   input  logic              dc_write_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [LINE_W-1:0] dc_data_i,
   output logic              mem_rqst_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              ic_mem_data_ready_o,
   output logic [LINE_W-1:0] ic_mem_data_o,
   output logic [ADDR_W-1:0] ic_mem_addr_o,
   output logic              dc_mem_data_ready_o,
   output logic [LINE_W-1:0] dc_mem_data_o,
   output logic [ADDR_W-1:0] dc_mem_addr_o,
   output logic              timeout_o
);

   typedef enum logic [1:0] {IDLE, IC_BUSY, DC_BUSY, RESP} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t              state_q, state_d;
   logic                last_dc_q, last_dc_d;
   logic [7:0]          wait_cnt_q, wait_cnt_d;
   logic                timeout_q, timeout_d;
   logic                mem_rqst_q, mem_rqst_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_data_q, mem_data_d;
   logic                ic_rdy_q, ic_rdy_d;
   logic [LINE_W-1:0]   ic_data_q, ic_data_d;
   logic [ADDR_W-1:0]   ic_addr_q, ic_addr_d;
   logic                dc_rdy_q, dc_rdy_d;
   logic [LINE_W-1:0]   dc_data_q, dc_data_d;
   logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
   logic                grant_ic, grant_dc;

   // On a tie the port that did not win last time gets the memory.
   assign grant_dc = dc_rqst_i && (!ic_rqst_i || !last_dc_q);
   assign grant_ic = ic_rqst_i && !grant_dc;

   always_comb begin
      state_d     = state_q;
      last_dc_d   = last_dc_q;
      wait_cnt_d  = wait_cnt_q;
      mem_rqst_d  = mem_rqst_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      ic_rdy_d    = 1'b0;
      ic_data_d   = ic_data_q;
      ic_addr_d   = ic_addr_q;
      dc_rdy_d    = 1'b0;
      dc_data_d   = dc_data_q;
      dc_addr_d   = dc_addr_q;
      case (state_q)
         IDLE: begin
            if (grant_ic) begin
               state_d     = IC_BUSY;
               last_dc_d   = 1'b0;
               mem_rqst_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = ic_addr_i;
               mem_data_d  = '0;
            end else if (grant_dc) begin
               state_d     = DC_BUSY;
               last_dc_d   = 1'b1;
               mem_rqst_d  = 1'b1;
               mem_write_d = dc_write_i;
               mem_addr_d  = dc_addr_i;
               mem_data_d  = dc_write_i ? dc_data_i : '0;
            end
         end
         IC_BUSY, DC_BUSY: begin
            if (mem_ready_i) begin
               state_d     = RESP;
               mem_rqst_d  = 1'b0;
               mem_write_d = 1'b0;
               wait_cnt_d  = '0;
               if (state_q == IC_BUSY) begin
                  ic_rdy_d  = 1'b1;
                  ic_addr_d = mem_addr_q;
                  ic_data_d = mem_data_i;
               end else begin
                  dc_rdy_d  = 1'b1;
                  dc_addr_d = mem_addr_q;
                  dc_data_d = mem_write_q ? '0 : mem_data_i;
               end
            end else if (wait_cnt_q != TMO) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Sticky: set in the same cycle the counter lands on the limit.
      timeout_d = timeout_q | ((state_q != IDLE) && (wait_cnt_d == TMO) && (wait_cnt_q != TMO));
   end

   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         state_q     <= IDLE;
         last_dc_q   <= 1'b0;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         mem_rqst_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         ic_rdy_q    <= 1'b0;
         ic_data_q   <= '0;
         ic_addr_q   <= '0;
         dc_rdy_q    <= 1'b0;
         dc_data_q   <= '0;
         dc_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         last_dc_q   <= last_dc_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         mem_rqst_q  <= mem_rqst_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         ic_rdy_q    <= ic_rdy_d;
         ic_data_q   <= ic_data_d;
         ic_addr_q   <= ic_addr_d;
         dc_rdy_q    <= dc_rdy_d;
         dc_data_q   <= dc_data_d;
         dc_addr_q   <= dc_addr_d;
      end
   end

   assign mem_rqst_o          = mem_rqst_q;
   assign mem_write_o         = mem_write_q;
   assign mem_addr_o          = mem_addr_q;
   assign mem_data_o          = mem_data_q;
   assign ic_mem_data_ready_o = ic_rdy_q;
   assign ic_mem_data_o       = ic_data_q;
   assign ic_mem_addr_o       = ic_addr_q;
   assign dc_mem_data_ready_o = dc_rdy_q;
   assign dc_mem_data_o       = dc_data_q;
   assign dc_mem_addr_o       = dc_addr_q;
   assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic          clk_i = 1'b0;
   logic          rsn_i;
   logic          ic_rqst_i;
   logic [19:0]   ic_addr_i;
   logic          dc_rqst_i;
   logic          dc_write_i;
   logic [19:0]   dc_addr_i;
   logic [127:0]  dc_data_i;
   logic          mem_rqst_o;
   logic          mem_write_o;
   logic [19:0]   mem_addr_o;
   logic [127:0]  mem_data_o;
   logic          mem_ready_i;
   logic [127:0]  mem_data_i;
   logic          ic_mem_data_ready_o;
   logic [127:0]  ic_mem_data_o;
   logic [19:0]   ic_mem_addr_o;
   logic          dc_mem_data_ready_o;
   logic [127:0]  dc_mem_data_o;
   logic [19:0]   dc_mem_addr_o;
   logic          timeout_o;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [127:0] D1 = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
   localparam logic [127:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] D3 = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10;
   localparam logic [127:0] D4 = 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d;
   localparam logic [127:0] D5 = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
   localparam logic [127:0] D6 = 128'h0000_0000_0000_0000_0000_0000_0000_0abc;
   localparam logic [127:0] ONES = {128{1'b1}};

   mem_arbiter dut (
      .clk_i               (clk_i),
      .rsn_i               (rsn_i),
      .ic_rqst_i           (ic_rqst_i),
      .ic_addr_i           (ic_addr_i),
      .dc_rqst_i           (dc_rqst_i),
      .dc_write_i          (dc_write_i),
      .dc_addr_i           (dc_addr_i),
      .dc_data_i           (dc_data_i),
      .mem_rqst_o          (mem_rqst_o),
      .mem_write_o         (mem_write_o),
      .mem_addr_o          (mem_addr_o),
      .mem_data_o          (mem_data_o),
      .mem_ready_i         (mem_ready_i),
      .mem_data_i          (mem_data_i),
      .ic_mem_data_ready_o (ic_mem_data_ready_o),
      .ic_mem_data_o       (ic_mem_data_o),
      .ic_mem_addr_o       (ic_mem_addr_o),
      .dc_mem_data_ready_o (dc_mem_data_ready_o),
      .dc_mem_data_o       (dc_mem_data_o),
      .dc_mem_addr_o       (dc_mem_addr_o),
      .timeout_o           (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rsn_i = 1'b1;
      ic_rqst_i = 1'b0; ic_addr_i = '0;
      dc_rqst_i = 1'b0; dc_write_i = 1'b0; dc_addr_i = '0; dc_data_i = '0;
      mem_ready_i = 1'b0; mem_data_i = '0;
      step(2);
      rsn_i = 1'b0;
      chk("rst_rqst", mem_rqst_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_ic_rdy", ic_mem_data_ready_o, 0);
      chk("rst_dc_rdy", dc_mem_data_ready_o, 0);
      chk("rst_tmo", timeout_o, 0);

      // icache fill, memory answers 4 cycles after the request rises
      ic_rqst_i = 1'b1; ic_addr_i = 20'h00A40;
      step();
      chk("ic_rqst", mem_rqst_o, 1);
      chk("ic_addr", mem_addr_o, 20'h00A40);
      chk("ic_write", mem_write_o, 0);
      step();
      ic_addr_i = 20'h11111;
      step(2);
      chk("ic_addr_held", mem_addr_o, 20'h00A40);
      mem_ready_i = 1'b1; mem_data_i = D1;
      step();
      mem_ready_i = 1'b0; ic_rqst_i = 1'b0;
      chk("ic_rdy", ic_mem_data_ready_o, 1);
      chk("ic_data", ic_mem_data_o, D1);
      chk("ic_faddr", ic_mem_addr_o, 20'h00A40);
      chk("ic_dc_quiet", dc_mem_data_ready_o, 0);
      chk("ic_rqst_drop", mem_rqst_o, 0);
      step();
      chk("ic_rdy_pulse", ic_mem_data_ready_o, 0);
      chk("ic_data_hold", ic_mem_data_o, D1);
      mem_ready_i = 1'b1; mem_data_i = D2;
      step();
      mem_ready_i = 1'b0;
      chk("spur_ic", ic_mem_data_ready_o, 0);
      chk("spur_dc", dc_mem_data_ready_o, 0);
      chk("spur_rqst", mem_rqst_o, 0);

      // first tie after reset goes to dcache
      ic_rqst_i = 1'b1; ic_addr_i = 20'h00200;
      dc_rqst_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 20'h00100;
      step();
      chk("tie1_addr", mem_addr_o, 20'h00100);
      chk("tie1_write", mem_write_o, 0);
      mem_ready_i = 1'b1; mem_data_i = D2;
      step();
      mem_ready_i = 1'b0; dc_rqst_i = 1'b0;
      chk("tie1_dc_rdy", dc_mem_data_ready_o, 1);
      chk("tie1_ic_rdy", ic_mem_data_ready_o, 0);
      chk("tie1_dc_data", dc_mem_data_o, D2);
      chk("tie1_dc_addr", dc_mem_addr_o, 20'h00100);
      step();
      chk("tie1_resp_rqst", mem_rqst_o, 0);
      step();
      chk("tie1_ic_rqst", mem_rqst_o, 1);
      chk("tie1_ic_addr", mem_addr_o, 20'h00200);
      mem_ready_i = 1'b1; mem_data_i = D3;
      step();
      mem_ready_i = 1'b0; ic_rqst_i = 1'b0;
      chk("tie1_ic_done", ic_mem_data_ready_o, 1);
      chk("tie1_ic_data", ic_mem_data_o, D3);
      chk("tie1_dc_quiet", dc_mem_data_ready_o, 0);
      step();

      // dcache write-back
      dc_rqst_i = 1'b1; dc_write_i = 1'b1; dc_addr_i = 20'h3FFFF; dc_data_i = ONES;
      step();
      chk("wb_write", mem_write_o, 1);
      chk("wb_data", mem_data_o, ONES);
      chk("wb_addr", mem_addr_o, 20'h3FFFF);
      mem_ready_i = 1'b1; mem_data_i = D4;
      step();
      mem_ready_i = 1'b0; dc_rqst_i = 1'b0; dc_write_i = 1'b0;
      chk("wb_rdy", dc_mem_data_ready_o, 1);
      chk("wb_rdata", dc_mem_data_o, 0);
      chk("wb_raddr", dc_mem_addr_o, 20'h3FFFF);
      chk("wb_wdrop", mem_write_o, 0);
      step();
      chk("wb_rdy_pulse", dc_mem_data_ready_o, 0);

      // second tie after a dcache grant goes to icache
      ic_rqst_i = 1'b1; ic_addr_i = 20'h00300;
      dc_rqst_i = 1'b1; dc_addr_i = 20'h00400; dc_data_i = D5;
      step();
      chk("tie2_addr", mem_addr_o, 20'h00300);
      chk("tie2_mdata", mem_data_o, 0);
      mem_ready_i = 1'b1; mem_data_i = D5;
      step();
      mem_ready_i = 1'b0; ic_rqst_i = 1'b0;
      chk("tie2_ic_rdy", ic_mem_data_ready_o, 1);
      step(2);
      chk("tie2_dc_addr", mem_addr_o, 20'h00400);
      mem_ready_i = 1'b1; mem_data_i = D6;
      step();
      mem_ready_i = 1'b0; dc_rqst_i = 1'b0;
      chk("tie2_dc_rdy", dc_mem_data_ready_o, 1);
      chk("tie2_dc_data", dc_mem_data_o, D6);
      step();

      // timeout: rises exactly 255 cycles after mem_rqst_o
      ic_rqst_i = 1'b1; ic_addr_i = 20'h00500;
      step();
      chk("tmo_rqst", mem_rqst_o, 1);
      step(254);
      chk("tmo_early", timeout_o, 0);
      step();
      chk("tmo_set", timeout_o, 1);
      step(44);
      chk("tmo_wait", mem_rqst_o, 1);
      chk("tmo_sticky", timeout_o, 1);
      mem_ready_i = 1'b1; mem_data_i = D1;
      step();
      mem_ready_i = 1'b0; ic_rqst_i = 1'b0;
      chk("tmo_done", ic_mem_data_ready_o, 1);
      step();
      chk("tmo_after", timeout_o, 1);

      // reset in the middle of a transaction
      dc_rqst_i = 1'b1; dc_write_i = 1'b0; dc_addr_i = 20'h00600;
      step();
      chk("mrst_rqst", mem_rqst_o, 1);
      step(2);
      rsn_i = 1'b1; dc_rqst_i = 1'b0;
      step();
      rsn_i = 1'b0;
      chk("mrst_rqst0", mem_rqst_o, 0);
      chk("mrst_addr0", mem_addr_o, 0);
      chk("mrst_tmo0", timeout_o, 0);
      chk("mrst_icdata0", ic_mem_data_o, 0);
      chk("mrst_dcaddr0", dc_mem_addr_o, 0);
      mem_ready_i = 1'b1; mem_data_i = D3;
      step();
      mem_ready_i = 1'b0;
      chk("mrst_no_rdy", dc_mem_data_ready_o, 0);
      chk("mrst_idle", mem_rqst_o, 0);
      dc_rqst_i = 1'b1;
      step();
      chk("mrst_regrant", mem_rqst_o, 1);
      chk("mrst_readdr", mem_addr_o, 20'h00600);
      mem_ready_i = 1'b1; mem_data_i = D6;
      step();
      mem_ready_i = 1'b0; dc_rqst_i = 1'b0;
      chk("mrst_rdy", dc_mem_data_ready_o, 1);
      chk("mrst_data", dc_mem_data_o, D6);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
